vga_request_gen: RTL and testbench
==================================

// Module: vga_request_gen
// PURPOSE
//  Source end of the VGA request interface consumed by the colour-tracker overlay path.
//  Generates HSYNC/VSYNC and blanking for a 640x480@60 frame from the 25 MHz iVgaClk.
//  Drives the pixel request lines and the raw {row,col} pixel address that the
//    ball-detection RAM and the overlay mux consume.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, clocks
//  H_SYNC    96   HSYNC pulse width, clocks
//  H_BP      48   horizontal back porch, clocks
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    VSYNC pulse width, lines
//  V_BP      33   vertical back porch, lines
// PORTS
//  iVgaClk        in   1   pixel clock; all logic runs on the rising edge
//  reset          in   1   asynchronous, active-high
//  iEnable        in   1   when low, counters hold and requests/syncs are forced inactive
//  oVgaHRequest   out  1   high while the horizontal counter is in the active region
//  oVgaVRequest   out  1   high while the vertical counter is in the active region
//  oVgaRequest    out  1   oVgaHRequest & oVgaVRequest (active pixel)
//  oPixelAddress  out  20  {row[9:0], col[9:0]} of the requested pixel
//  oVgaHs         out  1   HSYNC, active-low
//  oVgaVs         out  1   VSYNC, active-low
//  oVgaBlank_n    out  1   low outside the active area (DAC blanking)
//  oFrameStart    out  1   one-cycle pulse at col 0, row 0 of each frame
//  oLineStart     out  1   one-cycle pulse at col 0 of every active line
// BEHAVIOUR
//  - Reset values: h_cnt = 0, v_cnt = 0, all requests 0, oPixelAddress = 0.
//    oVgaHs = 1, oVgaVs = 1, oVgaBlank_n = 0, pulse outputs 0.
//  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//    H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
//  - v_cnt increments only on the h_cnt wrap and counts 0..V_TOTAL-1 (525), then wraps.
//  - Both counters wrapping on the same clock is the end-of-frame event: both go to 0 together.
//  - Region ordering per axis: active [0,ACTIVE), FP, SYNC, BP.
//    HSYNC is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VSYNC is likewise on v_cnt.
//  - All outputs are registered and decoded from the counter state.
//    Latency: counter state -> outputs = 1 clock, identical for every output, so the outputs stay mutually aligned.
//  - oPixelAddress = {v_cnt, h_cnt} while oVgaRequest = 1.
//    Outside the active area it holds its last active value, {479,639} after the final pixel.
//  - oVgaBlank_n = oVgaRequest.
//  - oLineStart fires with the first active pixel of a line; oFrameStart coincides with oLineStart on row 0.
//  - iEnable low: counters freeze; requests, blank_n and pulses are driven 0; syncs are driven 1.
//    When iEnable returns high, counting resumes from the frozen position. There is no re-sync.
//  - Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous).
//    The first frame after release starts at (0,0).
// CONFIGURATION
//  - Macro VGA_REQ_LOOKAHEAD_EN.
//  - Defined: oVgaHRequest, oVgaVRequest, oVgaRequest and oPixelAddress lead the syncs,
//    blank_n and pulse outputs by exactly 1 clock.
//    This matches the 1-cycle registered read of the downstream RAM, so RAM q lines up with oVgaBlank_n.
//    The lead is implemented by decoding those signals from (h_cnt+1, v_cnt carry).
//  - Undefined: all outputs are cycle-aligned as described in BEHAVIOUR.
// STRUCTURE
//  - Shared package vga_timing_pkg: the eight timing constants, H_TOTAL/V_TOTAL,
//    and the 20-bit address type with its {row,col} packing.
//  - One natural sub-module: vga_axis_counter.
//    Parameterised ACTIVE/FP/SYNC/BP; outputs count, wrap, active, sync_n.
//    Instantiated twice: the vertical instance is clock-enabled by the horizontal wrap.
// TESTING
//  1. Reset release, run one frame -> exactly 800*525 = 420000 clocks between oFrameStart pulses;
//     exactly 307200 clocks with oVgaRequest = 1.
//  2. Per line -> oVgaHs low for 96 clocks starting 656 clocks after oLineStart;
//     oVgaVs low for 2 lines starting at line 490.
//  3. Address sweep -> oPixelAddress = {0,0} with oFrameStart, {0,639} at the end of line 0,
//     {479,639} at the last active pixel, then held through blanking.
//  4. iEnable low for 100 clocks at col 300, row 10 -> outputs inactive;
//     after re-enable the first request carries address {10,300}.
//  5. Reset pulse at row 200 -> outputs at reset values within the same clock;
//     the next oFrameStart comes 1 clock after reset release (+ the 1-clock output latency).
//  6. With VGA_REQ_LOOKAHEAD_EN -> oVgaRequest rises exactly 1 clock before oVgaBlank_n on every line;
//     without it the two rise on the same clock.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants and pixel-address packing shared by the VGA request generator.
// Build option: VGA_REQ_LOOKAHEAD_EN (see vga_request_gen.sv).
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t row;
    cnt_t col;
  } pix_addr_t;

  function automatic pix_addr_t pack_addr(cnt_t row, cnt_t col);
    pix_addr_t a;
    a.row = row;
    a.col = col;
    return a;
  endfunction

endpackage

// File: rtl/vga_request_gen_if.sv
// Request/sync bundle between the VGA request source and the overlay path.
// master = source side, slave = consumer side.
interface vga_request_gen_if;
  import vga_timing_pkg::*;

  logic      iEnable;
  logic      oVgaHRequest;
  logic      oVgaVRequest;
  logic      oVgaRequest;
  pix_addr_t oPixelAddress;
  logic      oVgaHs;
  logic      oVgaVs;
  logic      oVgaBlank_n;
  logic      oFrameStart;
  logic      oLineStart;

  modport master (
    input  iEnable,
    output oVgaHRequest,
    output oVgaVRequest,
    output oVgaRequest,
    output oPixelAddress,
    output oVgaHs,
    output oVgaVs,
    output oVgaBlank_n,
    output oFrameStart,
    output oLineStart
  );

  modport slave (
    output iEnable,
    input  oVgaHRequest,
    input  oVgaVRequest,
    input  oVgaRequest,
    input  oPixelAddress,
    input  oVgaHs,
    input  oVgaVs,
    input  oVgaBlank_n,
    input  oFrameStart,
    input  oLineStart
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: counter over active/FP/SYNC/BP with wrap, active and sync decode.
// Build option: none.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output cnt_t count,
  output logic wrap,
  output logic active,
  output logic sync_n
);

  localparam int   TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam cnt_t LAST     = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END  = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_BEG = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_END = cnt_t'(ACTIVE + FP + SYNC);

  cnt_t count_q;
  cnt_t count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (wrap)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count  = count_q;
  assign active = count_q < ACT_END;
  assign sync_n = !((count_q >= SYNC_BEG) && (count_q < SYNC_END));

endmodule

// File: rtl/vga_request_gen.sv
// VGA 640x480@60 request/sync source with registered, mutually aligned outputs.
// Build option: VGA_REQ_LOOKAHEAD_EN makes requests/address lead syncs/blank by 1 clock.
module vga_request_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input logic iVgaClk,
  input logic reset,
  vga_request_gen_if.master bus
);

`ifdef VGA_REQ_LOOKAHEAD_EN
  localparam bit LOOKAHEAD = 1'b1;
`else
  localparam bit LOOKAHEAD = 1'b0;
`endif

  localparam cnt_t H_ACT_C = cnt_t'(H_ACT);
  localparam cnt_t V_ACT_C = cnt_t'(V_ACT);

  cnt_t h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic h_sync_n, v_sync_n;

  vga_axis_counter #(
    .ACTIVE(H_ACT), .FP(H_FRONT), .SYNC(H_PULSE), .BP(H_BACK)
  ) u_h (
    .clk(iVgaClk), .rst(reset), .en(bus.iEnable),
    .count(h_cnt), .wrap(h_wrap),
    .active(h_act), .sync_n(h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACT), .FP(V_FRONT), .SYNC(V_PULSE), .BP(V_BACK)
  ) u_v (
    .clk(iVgaClk), .rst(reset), .en(h_wrap),
    .count(v_cnt), .wrap(v_wrap),
    .active(v_act), .sync_n(v_sync_n)
  );

  cnt_t      h_la, v_la;
  logic      h_rq, v_rq;
  pix_addr_t rq_addr;

  logic      hreq_d, hreq_q;
  logic      vreq_d, vreq_q;
  logic      req_d, req_q;
  logic      hs_d, hs_q;
  logic      vs_d, vs_q;
  logic      blank_d, blank_q;
  logic      fs_d, fs_q;
  logic      ls_d, ls_q;
  pix_addr_t addr_d, addr_q;

  // Lookahead position is only meaningful while enabled, where the
  // wrap strobes mark exactly where the counters go next.
  always_comb begin
    h_la    = h_wrap ? '0 : h_cnt + 1'b1;
    v_la    = v_wrap ? '0 : (h_wrap ? v_cnt + 1'b1 : v_cnt);
    h_rq    = LOOKAHEAD ? (h_la < H_ACT_C) : h_act;
    v_rq    = LOOKAHEAD ? (v_la < V_ACT_C) : v_act;
    rq_addr = LOOKAHEAD ? pack_addr(v_la, h_la)
                        : pack_addr(v_cnt, h_cnt);
  end

  always_comb begin
    hreq_d  = 1'b0;
    vreq_d  = 1'b0;
    req_d   = 1'b0;
    hs_d    = 1'b1;
    vs_d    = 1'b1;
    blank_d = 1'b0;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    addr_d  = addr_q;
    if (bus.iEnable) begin
      hreq_d  = h_rq;
      vreq_d  = v_rq;
      req_d   = h_rq && v_rq;
      hs_d    = h_sync_n;
      vs_d    = v_sync_n;
      blank_d = h_act && v_act;
      ls_d    = (h_cnt == '0) && v_act;
      fs_d    = ls_d && (v_cnt == '0);
      if (req_d)
        addr_d = rq_addr;
    end
  end

  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      hreq_q  <= 1'b0;
      vreq_q  <= 1'b0;
      req_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      hreq_q  <= hreq_d;
      vreq_q  <= vreq_d;
      req_q   <= req_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.oVgaHRequest  = hreq_q;
  assign bus.oVgaVRequest  = vreq_q;
  assign bus.oVgaRequest   = req_q;
  assign bus.oPixelAddress = addr_q;
  assign bus.oVgaHs        = hs_q;
  assign bus.oVgaVs        = vs_q;
  assign bus.oVgaBlank_n   = blank_q;
  assign bus.oFrameStart   = fs_q;
  assign bus.oLineStart    = ls_q;

endmodule

// File: tb/tb_vga_request_gen.sv
// Bench for vga_request_gen: scaled-timing instance against a linear-position model,
// plus a full 640x480 instance for the real line timing.
module tb_vga_request_gen;
  import vga_timing_pkg::*;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_REQ_LOOKAHEAD_EN
  localparam int LEAD = 1;
`else
  localparam int LEAD = 0;
`endif

  typedef struct packed {
    logic hreq, vreq, req, hs, vs, blank, fs, ls;
    logic [19:0] addr;
  } outs_t;

  typedef struct packed {
    logic  rst;
    logic  en;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_full = 1'b1;
  always #20 clk = ~clk;

  vga_request_gen_if bus();
  vga_request_gen_if fbus();

  vga_request_gen #(
    .H_ACT(HA), .H_FRONT(HF), .H_PULSE(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_PULSE(VS), .V_BACK(VB)
  ) dut (.iVgaClk(clk), .reset(reset), .bus(bus));

  vga_request_gen u_full (.iVgaClk(clk), .reset(rst_full), .bus(fbus));

  int    errs = 0;
  int    checks = 0;
  int    pos = 0;
  logic [19:0] hold = '0;
  outs_t exp;

  function automatic outs_t mko(bit hq, bit vq, bit rq, bit hs, bit vs,
                                bit bl, bit fs, bit ls, int row, int col);
    outs_t o;
    logic [9:0] r, c;
    r = row[9:0];
    c = col[9:0];
    o = {hq, vq, rq, hs, vs, bl, fs, ls, r, c};
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.hreq  = bus.oVgaHRequest;
    o.vreq  = bus.oVgaVRequest;
    o.req   = bus.oVgaRequest;
    o.hs    = bus.oVgaHs;
    o.vs    = bus.oVgaVs;
    o.blank = bus.oVgaBlank_n;
    o.fs    = bus.oFrameStart;
    o.ls    = bus.oLineStart;
    o.addr  = bus.oPixelAddress;
    return o;
  endfunction

  function automatic vec_t mkv(bit rst, bit en, outs_t e);
    vec_t v;
    v.rst = rst;
    v.en  = en;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      if (errs <= 30)
        $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Model state is a linear pixel index; row/col fall out of div/mod.
  task automatic model_edge();
    int h, v, pr, hr, vr;
    logic [9:0] r10, c10;
    if (reset) begin
      exp  = mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      pos  = 0;
      hold = '0;
      return;
    end
    exp = mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    if (bus.iEnable) begin
      h  = pos % HT;
      v  = pos / HT;
      pr = (pos + LEAD) % FRAME;
      hr = pr % HT;
      vr = pr / HT;
      exp.hreq  = hr < HA;
      exp.vreq  = vr < VA;
      exp.req   = (hr < HA) && (vr < VA);
      exp.hs    = !(h >= HA + HF && h < HA + HF + HS);
      exp.vs    = !(v >= VA + VF && v < VA + VF + VS);
      exp.blank = (h < HA) && (v < VA);
      exp.ls    = (h == 0) && (v < VA);
      exp.fs    = (h == 0) && (v == 0);
      if (exp.req) begin
        r10  = vr[9:0];
        c10  = hr[9:0];
        hold = {r10, c10};
      end
      pos = (pos + 1) % FRAME;
    end
    exp.addr = hold;
  endtask

  task automatic step(string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk(nm, 32'(dut_outs()), 32'(exp));
  endtask

  task automatic run_until_fs(int maxc, output int n, output int nreq);
    n = 0;
    nreq = 0;
    do begin
      step("run");
      n++;
      if (bus.oVgaRequest) nreq++;
    end while (!bus.oFrameStart && n < maxc);
  endtask

  vec_t vec[7];

  initial begin
    int n, nr, k, kr, kb;
    bus.iEnable  = 1'b1;
    fbus.iEnable = 1'b1;

    vec[0] = mkv(1, 1, mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vec[1] = mkv(0, 1, mko(1, 1, 1, 1, 1, 1, 1, 1, 0, 0));
    vec[2] = mkv(0, 1, mko(1, 1, 1, 1, 1, 1, 0, 0, 0, 1));
    vec[3] = mkv(0, 0, mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    vec[4] = mkv(0, 1, mko(1, 1, 1, 1, 1, 1, 0, 0, 0, 2));
    vec[5] = mkv(1, 1, mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vec[6] = mkv(0, 1, mko(1, 1, 1, 1, 1, 1, 1, 1, 0, 0));

    for (int i = 0; i < 7; i++) begin
      reset       = vec[i].rst;
      bus.iEnable = vec[i].en;
      @(posedge clk);
      model_edge();
      #1;
`ifdef VGA_REQ_LOOKAHEAD_EN
      chk($sformatf("vec%0d", i), 32'(dut_outs()), 32'(exp));
`else
      chk($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vec[i].exp));
`endif
    end

    // frame period and active pixel count
    run_until_fs(2 * FRAME, n, nr);
    run_until_fs(2 * FRAME, n, nr);
    chk("frame_len", n, FRAME);
    chk("frame_req", nr, HA * VA);

    // hsync placement after line start
    n = 0;
    while (bus.oVgaHs && n < HT) begin step("hs_wait"); n++; end
    chk("hs_start", n, HA + HF);
    k = 0;
    while (!bus.oVgaHs && k < HT) begin step("hs_low"); k++; end
    chk("hs_width", k, HS);

    // vsync placement after frame start
    run_until_fs(2 * FRAME, n, nr);
    n = 0;
    while (bus.oVgaVs && n < FRAME) begin step("vs_wait"); n++; end
    chk("vs_start", n, (VA + VF) * HT);
    k = 0;
    while (!bus.oVgaVs && k < FRAME) begin step("vs_low"); k++; end
    chk("vs_width", k, VS * HT);

    // address sweep
    run_until_fs(2 * FRAME, n, nr);
    chk("addr_fs", bus.oPixelAddress, 0);
    repeat (HA - 1 - LEAD) step("sweep");
    chk("addr_eol0", bus.oPixelAddress, {10'd0, 10'(HA - 1)});
    step("sweep");
    chk("addr_eol0_hold", bus.oPixelAddress, {10'd0, 10'(HA - 1)});
    repeat ((VA - 1) * HT - 1) step("sweep");
    chk("last_req", bus.oVgaRequest, 1);
    chk("addr_last", bus.oPixelAddress, {10'(VA - 1), 10'(HA - 1)});
    step("sweep");
    chk("after_last_req", bus.oVgaRequest, 0);
    repeat (3 * HT) step("sweep");
    chk("addr_blank_hold", bus.oPixelAddress, {10'(VA - 1), 10'(HA - 1)});

    // enable drop at row 5, col 10
    run_until_fs(2 * FRAME, n, nr);
    repeat (5 * HT + 9) step("to_r5");
    bus.iEnable = 1'b0;
    repeat (100) step("en_low");
    chk("en_low_req", bus.oVgaRequest, 0);
    chk("en_low_blank", bus.oVgaBlank_n, 0);
    chk("en_low_hs", bus.oVgaHs, 1);
    bus.iEnable = 1'b1;
    step("resume");
    chk("resume_req", bus.oVgaRequest, 1);
    chk("resume_addr", bus.oPixelAddress, {10'd5, 10'(10 + LEAD)});

    // request vs blank rise alignment on three lines
    run_until_fs(2 * FRAME, n, nr);
    repeat (HA + 2) step("to_hblank");
    for (int l = 0; l < 3; l++) begin
      kr = -1;
      kb = -1;
      for (int c = 0; c < HT && kb < 0; c++) begin
        step("align");
        if (bus.oVgaRequest && kr < 0) kr = c;
        if (bus.oVgaBlank_n && kb < 0) kb = c;
      end
      chk($sformatf("rise_lead%0d", l), kb - kr, LEAD);
      repeat (HA + 2) step("align");
    end

    // async reset at row 8
    run_until_fs(2 * FRAME, n, nr);
    repeat (8 * HT + 4) step("to_r8");
    #5;
    reset = 1'b1;
    #1;
    model_edge();
    chk("rst_async", 32'(dut_outs()), 32'(mko(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)));
    step("rst_hold");
    step("rst_hold");
    reset = 1'b0;
    step("rst_rel");
    chk("rst_fs", bus.oFrameStart, 1);
    chk("rst_addr", bus.oPixelAddress, 0);

    // randomized enable/reset against the model
    for (int i = 0; i < 2500; i++) begin
      bus.iEnable = ($urandom_range(0, 9) != 0);
      reset       = ($urandom_range(0, 399) == 0);
      step("rand");
    end
    reset = 1'b0;

    // full-size timing: one real line
    rst_full = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!fbus.oLineStart && n < 10);
    chk("full_ls", n, 1);
    nr = fbus.oVgaRequest ? 1 : 0;
    n = 0;
    while (fbus.oVgaHs && n < 2000) begin
      @(posedge clk); #1; n++;
      if (fbus.oVgaRequest) nr++;
    end
    chk("full_hs_start", n, H_ACTIVE + H_FP);
    chk("full_line_req", nr, H_ACTIVE - LEAD);
    k = 0;
    while (!fbus.oVgaHs && k < 500) begin @(posedge clk); #1; k++; end
    chk("full_hs_width", k, H_SYNC);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
